// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the four-source interrupt front end.
// Latency/backpressure: none (definitions only).
package irq_pending_ctrl_pkg;

    localparam int N_SRC = 4;
    localparam int VEC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } irq_state_e;

    function automatic logic [N_SRC-1:0] onehot2to4(input logic [VEC_W-1:0] vec);
        logic [N_SRC-1:0] oh;
        oh = '0;
        oh[vec] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc.sv
// Combinational 4-to-2 fixed-priority encoder, bit 3 highest.
// Latency: zero cycles; no backpressure.
module irq_prio_enc_4 (
    input  logic [3:0] eligible,
    output logic [1:0] vec,
    output logic       any
);

    always_comb begin
        vec = 2'd0;
        if (eligible[3]) begin
            vec = 2'd3;
        end else if (eligible[2]) begin
            vec = 2'd2;
        end else if (eligible[1]) begin
            vec = 2'd1;
        end
        any = |eligible;
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Four-source interrupt front end: sync, edge detect into sticky pend, mask, priority select, req/ack.
// Latency: irq_req rises SYNC_STAGES+2 edges after an event; ack holds off the next vector for one GAP cycle. IRQ_LEVEL_EN selects level mode.
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int N_SRC       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic [1:0] irq_vec,
    output logic [3:0] pend
);

    import irq_pending_ctrl_pkg::*;

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
    logic [N_SRC-1:0] sync_out;
    logic [N_SRC-1:0] sync_dly_q, sync_dly_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] enc_vec;
    logic             enc_any;
    irq_state_e       state_q, state_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_dly_q;
    assign eligible = pend_q & mask;

    irq_prio_enc_4 u_prio_enc (
        .eligible (eligible),
        .vec      (enc_vec),
        .any      (enc_any)
    );

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
        sync_dly_d = sync_out;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    vec_d   = enc_vec;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Vector stays frozen here even if mask or pend move underneath it.
                if (irq_ack) begin
                    clr     = onehot2to4(vec_q);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef IRQ_LEVEL_EN
    // Level mode: pend tracks the synchronised lines; the source must drop its line to clear.
    always_comb begin
        pend_d = sync_out;
    end
`else
    // OR-ing rise after the clear lets a new event win over a same-cycle ack.
    always_comb begin
        pend_d = (pend_q & ~clr) | rise;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            sync_dly_q <= '0;
            pend_q     <= '0;
            vec_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            pend_q     <= pend_d;
            vec_q      <= vec_d;
            state_q    <= state_d;
        end
    end

    assign irq_req = (state_q == ST_REQ);
    assign irq_vec = vec_q;
    assign pend    = pend_q;

endmodule
